// File: rtl/axi_wr_burst_master.sv
// AXI4 write-burst master: one INCR burst per sequencer command, address-derived write data.
// Optional macro WR_BRESP_CNT_EN enables the saturating non-OKAY bresp counter on err_cnt.
module axi_wr_burst_master #(
    parameter int DATA_W  = 512,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 4,
    parameter int AXI_ID  = 0,
    parameter int MAX_LEN = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [3:0]            wr_burst_length,
    output logic                  wlast,
    output logic                  wr_finish,
    output logic                  busy,
    output logic                  cmd_err,
    output logic [15:0]           err_cnt,
    output logic [ID_W-1:0]       m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_W-1:0]       m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP, S_DONE} state_t;

    localparam logic [3:0] LP_MAX_LEN = 4'(MAX_LEN);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_len;
    logic [3:0]          r_beat;
    logic [31:0]         r_word;
    logic                r_aw_done;
    logic                r_w_done;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_wlast;
    logic                r_bready;
    logic                r_wr_finish;
    logic                r_cmd_err;

    logic                w_len_zero;
    logic                w_len_big;
    logic [3:0]          w_len_q;
    logic [3:0]          w_awlen;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_last_hs;
    logic                w_aw_fin;
    logic                w_w_fin;

    assign w_len_zero = (wr_burst_length == 4'd0);
    assign w_len_big  = (wr_burst_length > LP_MAX_LEN);
    assign w_len_q    = w_len_zero ? 4'd1 : (w_len_big ? LP_MAX_LEN : wr_burst_length);

    assign w_aw_hs   = r_awvalid & m_axi_awready;
    assign w_w_hs    = r_wvalid & m_axi_wready;
    assign w_last_hs = w_w_hs & r_wlast;
    // AW and W retire independently; either may finish in the same cycle as the other.
    assign w_aw_fin  = r_aw_done | w_aw_hs;
    assign w_w_fin   = r_w_done | w_last_hs;
    assign w_awlen   = r_len - 4'd1;

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= 4'd1;
            r_beat      <= 4'd0;
            r_word      <= 32'd0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_bready    <= 1'b0;
            r_wr_finish <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (wr_en) begin
                        r_addr    <= wr_addr;
                        r_len     <= w_len_q;
                        r_beat    <= 4'd0;
                        r_word    <= 32'(wr_addr);
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= (w_len_q == 4'd1);
                        if (w_len_zero || w_len_big) begin
                            r_cmd_err <= 1'b1;
                        end
                        r_state   <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    // NOTE: the W payload only advances on a handshake, so it is held while stalled.
                    if (w_w_hs) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_w_done <= 1'b1;
                        end else begin
                            r_beat  <= r_beat + 4'd1;
                            r_word  <= r_word + 32'd64;
                            r_wlast <= ((r_beat + 4'd2) == r_len);
                        end
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_wr_finish <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_wr_finish <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef WR_BRESP_CNT_EN
    logic [15:0] r_err_cnt;
    logic        w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= 16'd0;
        end else if (r_state == S_RESP && m_axi_bvalid && m_axi_bresp != 2'b00
                     && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt  = r_err_cnt;
    assign w_unused = &{1'b0, m_axi_bid};
`else
    logic w_unused;

    assign err_cnt  = 16'd0;
    assign w_unused = &{1'b0, m_axi_bid, m_axi_bresp};
`endif

    assign busy          = (r_state != S_IDLE);
    assign wr_finish     = r_wr_finish;
    assign cmd_err       = r_cmd_err;
    assign wlast         = w_last_hs;
    assign m_axi_awid    = ID_W'(AXI_ID);
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = {4'd0, w_awlen};
    assign m_axi_awsize  = 3'd6;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = {(DATA_W/32){r_word}};
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = r_wlast;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Directed bench for axi_wr_burst_master with a negedge-driven AXI slave model and protocol monitor.
module tb_axi_wr_burst_master;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int WORDS  = DATA_W / 32;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                wr_en = 1'b0;
    logic [ADDR_W-1:0]   wr_addr = '0;
    logic [3:0]          wr_burst_length = 4'd0;
    logic                wlast, wr_finish, busy, cmd_err;
    logic [15:0]         err_cnt;
    logic [ID_W-1:0]     m_axi_awid;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                m_axi_awvalid;
    logic                m_axi_awready = 1'b0;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast, m_axi_wvalid;
    logic                m_axi_wready = 1'b0;
    logic [ID_W-1:0]     m_axi_bid = 4'd0;
    logic [1:0]          m_axi_bresp = 2'b00;
    logic                m_axi_bvalid = 1'b0;
    logic                m_axi_bready;

    axi_wr_burst_master dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_burst_length(wr_burst_length), .wlast(wlast), .wr_finish(wr_finish),
        .busy(busy), .cmd_err(cmd_err), .err_cnt(err_cnt),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;

    // Slave behaviour knobs
    int       aw_delay = 0;
    bit       w_toggle = 1'b0;
    bit       b_early = 1'b0;
    logic [1:0] resp_val = 2'b00;
    int       aw_cnt = 0;
    bit       w_phase = 1'b1, b_armed = 1'b0, b_hs = 1'b0;

    // Monitor logs
    int aw_hs_cnt, wlast_cnt, fin_cnt, fin_cyc, aw_hs_cyc, w_last_cyc, proto_err, const_err, rep_err;
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] w_word_q[$];
    bit          w_last_q[$];
    bit          p_aw_stall = 1'b0, p_w_stall = 1'b0;
    logic [31:0] p_awaddr;
    logic [7:0]  p_awlen;
    logic [DATA_W-1:0] p_wdata;
    logic        p_wlast;

    initial begin : slave_monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
                aw_cnt = 0; w_phase = 1'b1; b_armed = 1'b0; b_hs = 1'b0;
            end else begin
                if (m_axi_awvalid) begin
                    m_axi_awready = (aw_cnt >= aw_delay);
                    aw_cnt++;
                end else begin
                    m_axi_awready = 1'b0;
                    aw_cnt = 0;
                end
                if (m_axi_wvalid) begin
                    m_axi_wready = w_toggle ? w_phase : 1'b1;
                    w_phase = !w_phase;
                end else begin
                    m_axi_wready = 1'b0;
                    w_phase = 1'b1;
                end
                // B responds one cycle after bready rises, or early (one-shot) when requested.
                if (m_axi_bvalid && b_hs) begin
                    m_axi_bvalid = 1'b0; b_hs = 1'b0; b_armed = 1'b0;
                end else begin
                    if (b_early && busy && !m_axi_bvalid) begin
                        m_axi_bvalid = 1'b1; b_early = 1'b0;
                    end else if (b_armed && !m_axi_bvalid) begin
                        m_axi_bvalid = 1'b1;
                    end else if (m_axi_bready && !m_axi_bvalid) begin
                        b_armed = 1'b1;
                    end
                    b_hs = m_axi_bvalid && m_axi_bready;
                end
                m_axi_bresp = resp_val;
            end
            #1;
            cyc++;
            if (p_aw_stall && (!m_axi_awvalid || m_axi_awaddr !== p_awaddr || m_axi_awlen !== p_awlen))
                proto_err++;
            if (p_w_stall && (!m_axi_wvalid || m_axi_wdata !== p_wdata || m_axi_wlast !== p_wlast))
                proto_err++;
            p_aw_stall = !reset && m_axi_awvalid && !m_axi_awready;
            p_w_stall  = !reset && m_axi_wvalid && !m_axi_wready;
            p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;
            p_wdata = m_axi_wdata;   p_wlast = m_axi_wlast;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_hs_cnt++; aw_hs_cyc = cyc;
                aw_addr_q.push_back(m_axi_awaddr); aw_len_q.push_back(m_axi_awlen);
                if (m_axi_awsize !== 3'd6 || m_axi_awburst !== 2'b01 || m_axi_awid !== 4'd0)
                    const_err++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_word_q.push_back(m_axi_wdata[31:0]); w_last_q.push_back(m_axi_wlast);
                if (m_axi_wdata !== {WORDS{m_axi_wdata[31:0]}}) rep_err++;
                if (m_axi_wstrb !== {(DATA_W/8){1'b1}}) const_err++;
                if (m_axi_wlast) w_last_cyc = cyc;
            end
            if (wlast) wlast_cnt++;
            if (wr_finish) begin fin_cnt++; fin_cyc = cyc; end
        end
    end

    task automatic clear_logs();
        aw_hs_cnt = 0; wlast_cnt = 0; fin_cnt = 0; fin_cyc = 0; aw_hs_cyc = 0; w_last_cyc = 0;
        proto_err = 0; const_err = 0; rep_err = 0;
        aw_addr_q.delete(); aw_len_q.delete(); w_word_q.delete(); w_last_q.delete();
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [3:0] l);
        @(negedge clk);
        wr_addr = a; wr_burst_length = l; wr_en = 1'b1;
        #2 t_start = cyc;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_fin(input int target, input int budget, input string name);
        for (int n = 0; n < budget && fin_cnt < target; n++) begin
            @(negedge clk); #2;
        end
        checks++;
        if (fin_cnt < target) begin
            errors++;
            $display("FAIL %s wr_finish timeout: got %0d pulses, expected %0d", name, fin_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, wlast, wr_finish, busy, cmd_err} !== 8'b0
            || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: aw/w/wl/br/wlast/fin/busy/err=%b err_cnt=%0d, expected all 0",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, wlast, wr_finish, busy, cmd_err}, err_cnt);
        end
        checks++;
        if (m_axi_awsize !== 3'd6 || m_axi_awburst !== 2'b01 || m_axi_awid !== 4'd0
            || m_axi_wstrb !== {(DATA_W/8){1'b1}}) begin
            errors++;
            $display("FAIL reset_consts: awsize=%0d awburst=%0d awid=%0d, expected 6/1/0 and wstrb all ones",
                     m_axi_awsize, m_axi_awburst, m_axi_awid);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] exp_w [4];
        exp_w = '{32'h0000_1000, 32'h0000_1040, 32'h0000_1080, 32'h0000_10C0};
        clear_logs();
        start_cmd(32'h0000_1000, 4'd4);
        wait_fin(1, 40, "single");
        checks++;
        if (fin_cyc - t_start !== 7) begin
            errors++; $display("FAIL single_latency: got %0d cycles, expected 7", fin_cyc - t_start);
        end
        checks++;
        if (aw_hs_cnt !== 1 || aw_len_q[0] !== 8'd3 || aw_addr_q[0] !== 32'h0000_1000) begin
            errors++;
            $display("FAIL single_aw: count=%0d awlen=%0d awaddr=%h, expected 1/3/00001000",
                     aw_hs_cnt, aw_len_q[0], aw_addr_q[0]);
        end
        checks++;
        if (w_word_q.size() !== 4) begin
            errors++; $display("FAIL single_beats: got %0d, expected 4", w_word_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_word_q[i] !== exp_w[i] || w_last_q[i] !== (i == 3)) begin
                errors++;
                $display("FAIL single_beat%0d: wdata=%h last=%0d, expected %h last=%0d",
                         i, w_word_q[i], w_last_q[i], exp_w[i], (i == 3));
            end
        end
        checks++;
        if (wlast_cnt !== 1 || rep_err !== 0 || const_err !== 0 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL single_misc: wlast pulses=%0d rep_err=%0d const_err=%0d cmd_err=%0d, expected 1/0/0/0",
                     wlast_cnt, rep_err, const_err, cmd_err);
        end
    endtask

    task automatic test_stall();
        clear_logs();
        aw_delay = 5; w_toggle = 1'b1; b_early = 1'b1;
        start_cmd(32'h0000_2000, 4'd4);
        wait_fin(1, 60, "stall");
        checks++;
        if (aw_hs_cyc - t_start !== 6 || w_last_cyc - t_start !== 7) begin
            errors++;
            $display("FAIL stall_handshakes: aw at +%0d, last W at +%0d, expected +6/+7",
                     aw_hs_cyc - t_start, w_last_cyc - t_start);
        end
        checks++;
        if (fin_cyc - t_start !== 9) begin
            errors++; $display("FAIL stall_finish: wr_finish at +%0d, expected +9", fin_cyc - t_start);
        end
        checks++;
        if (proto_err !== 0 || aw_hs_cnt !== 1 || wlast_cnt !== 1) begin
            errors++;
            $display("FAIL stall_protocol: proto_err=%0d aw_hs=%0d wlast=%0d, expected 0/1/1",
                     proto_err, aw_hs_cnt, wlast_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_word_q[i] !== 32'h0000_2000 + 32'(i) * 32'd64) begin
                errors++;
                $display("FAIL stall_beat%0d: wdata=%h, expected %h", i, w_word_q[i], 32'h0000_2000 + 32'(i) * 32'd64);
            end
        end
        aw_delay = 0; w_toggle = 1'b0; b_early = 1'b0;
    endtask

    task automatic test_len_clamp();
        logic [3:0]  req [4];
        logic [7:0]  exp_len [4];
        logic [31:0] base [4];
        bit          exp_err [4];
        req = '{4'd8, 4'd1, 4'd0, 4'd12};
        exp_len = '{8'd7, 8'd0, 8'd0, 8'd7};
        base = '{32'h0000_3000, 32'h0000_3400, 32'h0000_3800, 32'h0000_3C00};
        exp_err = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int b = 0; b < 4; b++) begin
            clear_logs();
            start_cmd(base[b], req[b]);
            wait_fin(1, 40, "len_clamp");
            checks++;
            if (aw_len_q[0] !== exp_len[b] || w_word_q.size() !== int'(exp_len[b]) + 1
                || cmd_err !== exp_err[b]) begin
                errors++;
                $display("FAIL len_clamp_req%0d: awlen=%0d beats=%0d cmd_err=%0d, expected %0d/%0d/%0d",
                         req[b], aw_len_q[0], w_word_q.size(), cmd_err, exp_len[b], exp_len[b] + 1, exp_err[b]);
            end
            checks++;
            if (w_last_q[w_last_q.size() - 1] !== 1'b1
                || w_word_q[w_word_q.size() - 1] !== base[b] + 32'(exp_len[b]) * 32'd64) begin
                errors++;
                $display("FAIL len_clamp_last%0d: last flag=%0d word=%h, expected 1/%h", req[b],
                         w_last_q[w_last_q.size() - 1], w_word_q[w_word_q.size() - 1],
                         base[b] + 32'(exp_len[b]) * 32'd64);
            end
        end
    endtask

    task automatic test_bresp();
        logic [15:0] exp_cnt;
`ifdef WR_BRESP_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        resp_val = 2'b10;
        for (int b = 0; b < 3; b++) begin
            clear_logs();
            start_cmd(32'h0000_9000 + 32'(b) * 32'h40, 4'd1);
            wait_fin(1, 40, "bresp");
        end
        resp_val = 2'b00;
        checks++;
        if (err_cnt !== exp_cnt) begin
            errors++; $display("FAIL bresp_count: err_cnt=%0d, expected %0d", err_cnt, exp_cnt);
        end
        clear_logs();
        start_cmd(32'h0000_9100, 4'd2);
        wait_fin(1, 40, "bresp_okay");
        checks++;
        if (err_cnt !== exp_cnt) begin
            errors++; $display("FAIL bresp_okay: err_cnt=%0d, expected %0d", err_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_midburst();
        clear_logs();
        start_cmd(32'h0000_6000, 4'd8);
        for (int n = 0; n < 40 && w_word_q.size() < 2; n++) begin
            @(negedge clk); #2;
        end
        @(negedge clk); #2;
        reset = 1'b1;
        @(negedge clk); #2;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, wr_finish, busy, cmd_err} !== 7'b0
            || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midreset_state: aw/w/wl/br/fin/busy/err=%b err_cnt=%0d, expected all 0",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, wr_finish, busy, cmd_err}, err_cnt);
        end
        reset = 1'b0;
        clear_logs();
        repeat (10) @(negedge clk);
        #2;
        checks++;
        if (fin_cnt !== 0 || aw_hs_cnt !== 0 || w_word_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: fin=%0d aw_hs=%0d beats=%0d, expected 0/0/0",
                     fin_cnt, aw_hs_cnt, w_word_q.size());
        end
        start_cmd(32'h0000_7000, 4'd2);
        wait_fin(1, 40, "midreset_recover");
        checks++;
        if (fin_cyc - t_start !== 5 || aw_len_q[0] !== 8'd1 || w_word_q[0] !== 32'h0000_7000
            || w_word_q[1] !== 32'h0000_7040) begin
            errors++;
            $display("FAIL midreset_recover: latency=%0d awlen=%0d w0=%h w1=%h, expected 5/1/00007000/00007040",
                     fin_cyc - t_start, aw_len_q[0], w_word_q[0], w_word_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  lens [3];
        logic [31:0] addrs [3];
        int          k;
        bit          prev_fin;
        int          w;
        lens = '{4'd2, 4'd5, 4'd3};
        addrs = '{32'hFFFF_FFC0, 32'h0000_4000, 32'h0000_8000};
        clear_logs();
        @(negedge clk);
        wr_addr = addrs[0]; wr_burst_length = lens[0]; wr_en = 1'b1;
        k = 0; prev_fin = 1'b0;
        for (int n = 0; n < 300 && k < 3; n++) begin
            @(negedge clk); #2;
            if (prev_fin) begin
                k++;
                if (k < 3) begin
                    wr_addr = addrs[k]; wr_burst_length = lens[k];
                end else begin
                    wr_en = 1'b0;
                end
            end else if (busy) begin
                wr_addr = 32'hDEAD_BEC0; wr_burst_length = 4'd1;
            end
            prev_fin = wr_finish;
        end
        wr_en = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        checks++;
        if (k !== 3 || aw_hs_cnt !== 3 || fin_cnt !== 3) begin
            errors++;
            $display("FAIL b2b_count: bursts=%0d aw_hs=%0d wr_finish=%0d, expected 3/3/3", k, aw_hs_cnt, fin_cnt);
        end
        w = 0;
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (aw_len_q[b] !== 8'(lens[b]) - 8'd1 || aw_addr_q[b] !== addrs[b]) begin
                errors++;
                $display("FAIL b2b_aw%0d: awlen=%0d awaddr=%h, expected %0d/%h",
                         b, aw_len_q[b], aw_addr_q[b], lens[b] - 4'd1, addrs[b]);
            end
            for (int i = 0; i < int'(lens[b]); i++) begin
                checks++;
                if (w_word_q[w] !== addrs[b] + 32'(i) * 32'd64) begin
                    errors++;
                    $display("FAIL b2b_burst%0d_beat%0d: wdata=%h, expected %h",
                             b, i, w_word_q[w], addrs[b] + 32'(i) * 32'd64);
                end
                w++;
            end
        end
        checks++;
        if (w_word_q.size() !== 10 || proto_err !== 0 || wlast_cnt !== 3) begin
            errors++;
            $display("FAIL b2b_misc: beats=%0d proto_err=%0d wlast=%0d, expected 10/0/3",
                     w_word_q.size(), proto_err, wlast_cnt);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        clear_logs();
        test_reset();
        test_single();
        test_stall();
        test_len_clamp();
        test_bresp();
        test_reset_midburst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
